// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants: key length codes, Nk/Nr, xtime, S-box
package aes_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'd0,
        KEY_192 = 2'd1,
        KEY_256 = 2'd2,
        KEY_BAD = 2'd3
    } key_len_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } ks_state_t;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        logic [3:0] nk;
        case (len)
            KEY_128: nk = 4'(NK_128);
            KEY_192: nk = 4'(NK_192);
            default: nk = 4'(NK_256);
        endcase
        return nk;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        return nk_of(len) + 4'd6;
    endfunction

    function automatic int key_bits(input logic [1:0] len);
        return 32 * int'(nk_of(len));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data_byte,
    output logic [7:0] sub_byte
);

    assign sub_byte = SBOX[data_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128/192/256 key expansion, one round key per stream beat
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_KEY_WIDTH = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [MAX_KEY_WIDTH-1:0] key_in,
    input  logic [1:0]               key_len,
    input  logic                     start,
    output logic                     busy,
    output logic                     err,
    output logic                     rk_valid,
    input  logic                     rk_ready,
    output logic [127:0]             rk_data,
    output logic [3:0]               rk_index,
    output logic                     rk_last
);

    ks_state_t              state;
    logic [MAX_KEY_WIDTH-1:0] key_q;
    logic [1:0]             len_q;
    logic [5:0]             idx;
    logic [2:0]             mod_cnt;
    logic [7:0]             rcon;
    logic [31:0]            win [8];
    logic [95:0]            asm_q;

    logic [255:0]           key_ext;
    logic [31:0]            key_words [8];
    logic [31:0]            prev_w;
    logic [31:0]            old_w;
    logic [31:0]            sub_in;
    logic [31:0]            sub_out;
    logic [31:0]            new_w;
    logic [3:0]             nk;
    logic [3:0]             nr;
    logic                   stall;
    logic                   last_word;
    logic                   start_ok;

    // Left-justify the captured key into a 256-bit frame so word k is always at the same offset.
    assign key_ext = 256'(key_q) << (256 - MAX_KEY_WIDTH);

    for (genvar k = 0; k < 8; k++) begin : g_key_words
        assign key_words[k] = key_ext[255-32*k -: 32];
    end

    assign nk        = nk_of(len_q);
    assign nr        = nr_of(len_q);
    assign prev_w    = win[0];
    assign old_w     = win[nk[2:0] - 3'd1];
    assign sub_in    = (mod_cnt == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    assign stall     = (idx[1:0] == 2'd3) && rk_valid && !rk_ready;
    assign last_word = (idx == {nr, 2'b11});
    assign start_ok  = (key_len != KEY_BAD) && (key_bits(key_len) <= MAX_KEY_WIDTH);

    for (genvar b = 0; b < 4; b++) begin : g_sub_word
        aes_sbox u_sbox (
            .data_byte (sub_in[8*b +: 8]),
            .sub_byte  (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        new_w = old_w ^ prev_w;
        if (idx < {2'b00, nk}) begin
            new_w = key_words[idx[2:0]];
        end else if (mod_cnt == 3'd0) begin
            new_w = old_w ^ sub_out ^ {rcon, 24'h0};
        end else if (nk == 4'd8 && mod_cnt == 3'd4) begin
            new_w = old_w ^ sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            rk_last  <= 1'b0;
            key_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            mod_cnt  <= '0;
            rcon     <= 8'h01;
            asm_q    <= '0;
            for (int k = 0; k < 8; k++) win[k] <= '0;
        end else begin
            err <= 1'b0;
            if (rk_valid && rk_ready) rk_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            key_q   <= key_in;
                            len_q   <= key_len;
                            idx     <= '0;
                            mod_cnt <= '0;
                            rcon    <= 8'h01;
                            busy    <= 1'b1;
                            state   <= ST_GEN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    if (!stall) begin
                        win[0] <= new_w;
                        for (int k = 1; k < 8; k++) win[k] <= win[k-1];
                        asm_q   <= {asm_q[63:0], new_w};
                        idx     <= idx + 6'd1;
                        mod_cnt <= (mod_cnt == nk[2:0] - 3'd1) ? 3'd0 : mod_cnt + 3'd1;
                        if (idx >= {2'b00, nk} && mod_cnt == 3'd0) rcon <= xtime(rcon);
                        if (idx[1:0] == 2'd3) begin
                            rk_valid <= 1'b1;
                            rk_data  <= {asm_q, new_w};
                            rk_index <= idx[5:2];
                            rk_last  <= last_word;
                        end
                        if (last_word) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rk_valid && rk_ready && rk_last) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
